sel_mux_pipe: RTL
=================

# sel_mux_pipe

Parametrised, registered priority selector for the datapath, replacing fixed-width, fixed-count combinational select muxes with an N-channel, W-bit, one-stage pipelined mux. Each accepted transaction presents CHANNELS data words plus a select vector, and the block registers the winning word. Winner selection is fixed priority (lowest index wins), or round-robin when compiled in. Unlike a combinational mux, the output never floats: an empty select yields zero with a flag, multi-hot selects are flagged and counted, and a valid/ready handshake allows back-pressure.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- CHANNELS, 3, number of input channels (2..16)
- IDXW, $clog2(CHANNELS), width of the grant index (derived; not to be overridden)

- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_sel  input  CHANNELS  select vector; bit i requests channel i
- in_valid  input  1  in_data/in_sel valid this cycle
- in_ready  output  1  block accepts this cycle
- out_data  output  WIDTH  registered selected word
- out_idx  output  IDXW  index of the granted channel
- out_none  output  1  registered: in_sel was all-zero for this word
- out_conflict  output  1  registered: more than one in_sel bit was set for this word
- out_valid  output  1  out_* hold a word
- out_ready  input  1  downstream accepts out_*
- conflict_cnt  output  8  saturating count of accepted multi-hot transfers

## Operation
- Accept: acc = in_valid && in_ready, with in_ready = !out_valid || out_ready (combinational, no bubble on continuous flow).
- On acc:
  - out_data <= in_data of granted channel.
  - out_idx <= granted index.
  - out_none <= (in_sel == 0).
  - out_conflict <= popcount(in_sel) > 1.
  - out_valid <= 1.
- No selection: out_data <= 0, out_idx <= 0, out_none <= 1, out_valid <= 1. The word is still delivered.
- Fixed priority (default): grant = lowest set index in in_sel.
- out_valid clears when out_ready && !acc. All out_* hold stable while out_valid && !out_ready.
- conflict_cnt increments on each acc with out_conflict condition; saturates at 255 and never wraps.
- in_valid low: in_sel/in_data ignored, no state change.

## Timing
- Latency: 1 cycle, from accepted input to out_valid.
- Throughput: 1 word/cycle while out_ready = 1.
- Reset (async assert, sync-safe deassert handled upstream):
  - out_data = 0
  - out_idx = 0
  - out_none = 0
  - out_conflict = 0
  - out_valid = 0
  - conflict_cnt = 0
  - round-robin pointer = CHANNELS-1
- in_ready = 1 during and immediately after reset.
- Simultaneous out_ready && acc: old word leaves, new word loads in the same edge; out_valid stays 1.
- Reset mid-stream: the in-flight word is dropped. No partial update survives.

## Configuration
- SEL_MUX_RR_EN defined:
  - Round-robin grant. Register last_idx (reset CHANNELS-1).
  - Grant = first set bit of in_sel searching from (last_idx+1) mod CHANNELS upward, wrapping.
  - last_idx <= grant on acc with in_sel != 0.
  - last_idx unchanged on empty select or when not accepted.
- SEL_MUX_RR_EN undefined:
  - Fixed lowest-index priority as above.
  - No pointer register exists.

## Test plan
- Reset, then in_valid=1, in_sel=3'b010, in_data={C,B,A} = {16'h3333,16'h2222,16'h1111}, out_ready=1.
  - Next cycle: out_data=16'h2222, out_idx=1, out_valid=1, out_none=0, out_conflict=0.
- in_sel=3'b000.
  - out_data=0, out_none=1, out_valid=1; conflict_cnt unchanged.
- Fixed priority, in_sel=3'b110.
  - out_idx=1, out_conflict=1, conflict_cnt=1.
  - 300 such transfers: conflict_cnt=255 (saturated).
- Back-pressure: out_ready=0 for 4 cycles with in_valid=1.
  - First word held stable, in_ready=0 after the first accept, no data loss.
  - out_ready=1: words emerge in order with no gap.
- SEL_MUX_RR_EN, in_sel=3'b111 for 4 accepted cycles.
  - out_idx sequence 0,1,2,0.
  - Insert in_sel=0: the next 3'b111 grant continues the sequence unchanged.
- Assert rst_n=0 while out_valid=1.
  - All outputs zero immediately (asynchronous).
  - RR restarts at index 0.

Source files
------------

// File: rtl/sel_mux_pipe.sv
// -----------------------------------------------------------------------------
// sel_mux_pipe
//
// This is a registered N-channel priority selector with a one-stage pipeline.
// Each accepted transaction carries CHANNELS data words and a select vector.
// The block registers the word of the granted channel and its index. It also
// registers two flags: one for an empty select and one for a multi-hot select.
// A valid/ready pair on each side allows back-pressure. The output handshake
// accepts a new word on the same edge that the old word leaves.
//
// Grant policy:
//   default            - fixed priority, the lowest set index wins
//   SEL_MUX_RR_EN      - round-robin; the search starts one past the last grant
//
// Parameters:
//   WIDTH        data word width in bits (>= 1)
//   CHANNELS     number of input channels (2..16)
//   IDXW         grant index width, derived from CHANNELS
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_data      channel i at bits [i*WIDTH +: WIDTH]
//   in_sel       select vector, bit i requests channel i
//   in_valid     in_data/in_sel valid this cycle
//   in_ready     block accepts this cycle (combinational)
//   out_data     registered selected word (zero on empty select)
//   out_idx      registered granted index (zero on empty select)
//   out_none     registered: select was all-zero
//   out_conflict registered: more than one select bit was set
//   out_valid    out_* hold a word
//   out_ready    downstream accepts out_*
//   conflict_cnt saturating count of accepted multi-hot transfers
// -----------------------------------------------------------------------------
module sel_mux_pipe #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 3,
    localparam int IDXW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [IDXW-1:0]           out_idx,
    output logic                      out_none,
    output logic                      out_conflict,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                conflict_cnt
);

    // Returns the lowest set index. Returns 0 when nothing is set; the caller
    // handles the empty case separately through out_none.
    function automatic logic [IDXW-1:0] prio_grant(input logic [CHANNELS-1:0] sel);
        logic [IDXW-1:0] g;
        logic            found;
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel[i] && !found) begin
                g     = IDXW'(i);
                found = 1'b1;
            end
        end
        return g;
    endfunction

`ifdef SEL_MUX_RR_EN
    // Returns the first set bit at or after (last+1) mod CHANNELS, wrapping
    // around. Because k runs to CHANNELS, 'last' itself is checked last. A
    // single requester therefore keeps winning.
    function automatic logic [IDXW-1:0] rr_grant(input logic [CHANNELS-1:0] sel,
                                                 input logic [IDXW-1:0]     last);
        logic [IDXW-1:0] g;
        logic            found;
        int              j;
        g     = '0;
        found = 1'b0;
        for (int k = 1; k <= CHANNELS; k++) begin
            j = (int'(last) + k) % CHANNELS;
            if (sel[j] && !found) begin
                g     = IDXW'(j);
                found = 1'b1;
            end
        end
        return g;
    endfunction
`endif

    function automatic logic is_multi_hot(input logic [CHANNELS-1:0] sel);
        int n;
        n = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel[i]) n++;
        end
        return (n > 1);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    // ------------------------------------------------------------------ p0
    logic                 acc_p0;
    logic                 none_p0;
    logic                 conflict_p0;
    logic [IDXW-1:0]      grant_p0;
    logic [WIDTH-1:0]     data_p0;

    logic                 vld_p1;
    logic [WIDTH-1:0]     data_p1;
    logic [IDXW-1:0]      idx_p1;
    logic                 none_p1;
    logic                 conflict_p1;
    logic [7:0]           cnt_p1;

    // A held word blocks intake unless it leaves this same cycle.
    assign in_ready    = !vld_p1 || out_ready;
    assign acc_p0      = in_valid && in_ready;
    assign none_p0     = (in_sel == '0);
    assign conflict_p0 = is_multi_hot(in_sel);

`ifdef SEL_MUX_RR_EN
    logic [IDXW-1:0] last_idx_p1;

    assign grant_p0 = rr_grant(in_sel, last_idx_p1);

    // The pointer moves only on a real grant. Empty selects leave it where
    // it is, so the rotation continues after them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idx_p1 <= IDXW'(CHANNELS - 1);
        end else if (acc_p0 && !none_p0) begin
            last_idx_p1 <= grant_p0;
        end
    end
`else
    assign grant_p0 = prio_grant(in_sel);
`endif

    // The empty-select gate forces zero data. Without it channel 0 would
    // leak through when grant_p0 defaults to 0.
    always_comb begin
        data_p0 = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!none_p0 && (int'(grant_p0) == i)) begin
                data_p0 = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------ p1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            data_p1     <= '0;
            idx_p1      <= '0;
            none_p1     <= 1'b0;
            conflict_p1 <= 1'b0;
        end else if (acc_p0) begin
            vld_p1      <= 1'b1;
            data_p1     <= data_p0;
            idx_p1      <= none_p0 ? '0 : grant_p0;
            none_p1     <= none_p0;
            conflict_p1 <= conflict_p0;
        end else if (out_ready) begin
            vld_p1      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1 <= '0;
        end else if (acc_p0 && conflict_p0) begin
            cnt_p1 <= sat_inc8(cnt_p1);
        end
    end

    assign out_valid    = vld_p1;
    assign out_data     = data_p1;
    assign out_idx      = idx_p1;
    assign out_none     = none_p1;
    assign out_conflict = conflict_p1;
    assign conflict_cnt = cnt_p1;

endmodule
